color_sensor_frontend: RTL and testbench

Drives a TCS3200-class light-to-frequency colour sensor and produces the normalised red/green/blue values consumed by the colour identifier stage.
- Per measurement: steps the photodiode filter through clear, red, green, blue.
- For each filter: waits a settle time, then counts sensor output rising edges over a fixed gate window.
- Then normalises each colour count against the clear count using a shared sequential divider.
- Publishes all three results together with a one-cycle valid strobe.

---
 rtl/color_sensor_frontend.sv | 187 ++++++++++++++++++
 tb/tb_color_sensor_frontend.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_sensor_frontend.sv
// rtl/color_sensor_frontend.sv - TCS3200 filter sequencer, gated edge counter and RGB normaliser
module color_sensor_frontend #(
    parameter int unsigned GATE_CYCLES   = 500000,
    parameter int unsigned SETTLE_CYCLES = 5000,
    parameter int unsigned NORM_MAX      = 1023,
    parameter int unsigned COUNT_BITS    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sensor_out,
    output logic        s2,
    output logic        s3,
    output logic [15:0] red_norm,
    output logic [15:0] green_norm,
    output logic [15:0] blue_norm,
    output logic        valid,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, SETTLE, GATE, DIV, DONE} state_t;

    localparam logic [15:0] COUNT_MAX   = 16'((33'd1 << COUNT_BITS) - 33'd1);
    localparam logic [25:0] NORM_CAP    = 26'(NORM_MAX);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] GATE_LOAD   = 32'(GATE_CYCLES - 1);

    state_t      state;
    logic [31:0] timer;
    logic [1:0]  filt;
    logic        sync1, sync2, sync_prev, rise;
    logic [15:0] cnt, cnt_inc;
    logic [15:0] cnt_clear, cnt_red, cnt_green, cnt_blue;
    logic [1:0]  div_ch;
    logic        div_load;
    logic [4:0]  div_cnt;
    logic [15:0] rem, rem_next, div_src, quo_sat;
    logic [25:0] quo, quo_next;
    logic [16:0] shifted;
    logic        ge;
    logic [15:0] hold_r, hold_g, hold_b;

    assign busy = (state != IDLE);
    assign rise = sync2 & ~sync_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= sensor_out;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    // One restoring-division step per cycle; dividend bits shift out of quo into rem.
    always_comb begin
        cnt_inc = (rise && cnt != COUNT_MAX) ? cnt + 16'd1 : cnt;
        case (div_ch)
            2'd0:    div_src = cnt_red;
            2'd1:    div_src = cnt_green;
            default: div_src = cnt_blue;
        endcase
        shifted  = {rem, quo[25]};
        ge       = shifted >= {1'b0, cnt_clear};
        rem_next = ge ? 16'(shifted - {1'b0, cnt_clear}) : shifted[15:0];
        quo_next = {quo[24:0], ge};
        if (cnt_clear == 16'd0)
            quo_sat = 16'd0;
        else if (quo_next > NORM_CAP)
            quo_sat = 16'(NORM_MAX);
        else
            quo_sat = quo_next[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            filt       <= '0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            cnt_clear  <= '0;
            cnt_red    <= '0;
            cnt_green  <= '0;
            cnt_blue   <= '0;
            div_ch     <= '0;
            div_load   <= 1'b0;
            div_cnt    <= '0;
            rem        <= '0;
            quo        <= '0;
            hold_r     <= '0;
            hold_g     <= '0;
            hold_b     <= '0;
            red_norm   <= '0;
            green_norm <= '0;
            blue_norm  <= '0;
            valid      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    s2 <= 1'b1;
                    s3 <= 1'b0;
                    if (start) begin
                        state <= SETTLE;
                        timer <= SETTLE_LOAD;
                        filt  <= 2'd0;
                    end
                end
                SETTLE: begin
                    if (timer == '0) begin
                        state <= GATE;
                        timer <= GATE_LOAD;
                        cnt   <= '0;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                GATE: begin
                    cnt <= cnt_inc;
                    if (timer == '0) begin
                        case (filt)
                            2'd0:    cnt_clear <= cnt_inc;
                            2'd1:    cnt_red   <= cnt_inc;
                            2'd2:    cnt_green <= cnt_inc;
                            default: cnt_blue  <= cnt_inc;
                        endcase
                        if (filt == 2'd3) begin
                            state    <= DIV;
                            div_ch   <= 2'd0;
                            div_load <= 1'b1;
                            {s2, s3} <= 2'b10;
                        end else begin
                            state <= SETTLE;
                            timer <= SETTLE_LOAD;
                            filt  <= filt + 2'd1;
                            case (filt)
                                2'd0:    {s2, s3} <= 2'b00;
                                2'd1:    {s2, s3} <= 2'b11;
                                default: {s2, s3} <= 2'b01;
                            endcase
                        end
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                DIV: begin
                    if (div_load) begin
                        quo      <= {div_src, 10'd0};
                        rem      <= '0;
                        div_cnt  <= 5'd25;
                        div_load <= 1'b0;
                    end else begin
                        quo <= quo_next;
                        rem <= rem_next;
                        if (div_cnt == 5'd0) begin
                            case (div_ch)
                                2'd0:    hold_r <= quo_sat;
                                2'd1:    hold_g <= quo_sat;
                                default: hold_b <= quo_sat;
                            endcase
                            if (div_ch == 2'd2) begin
                                state <= DONE;
                            end else begin
                                div_ch   <= div_ch + 2'd1;
                                div_load <= 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt - 5'd1;
                        end
                    end
                end
                DONE: begin
                    red_norm   <= hold_r;
                    green_norm <= hold_g;
                    blue_norm  <= hold_b;
                    valid      <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_color_sensor_frontend.sv
// tb/tb_color_sensor_frontend.sv - directed vector bench for color_sensor_frontend
module tb_color_sensor_frontend;
    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    logic        rst, start, sensor_out;
    logic        s2, s3, valid, busy;
    logic [15:0] red_norm, green_norm, blue_norm;
    logic        start_b, sensor_b;
    logic        s2_b, s3_b, valid_b, busy_b;
    logic [15:0] red_b, green_b, blue_b;

    int n_cmp = 0;
    int n_fail = 0;
    int mode_a = 1;
    logic [1:0] hist [0:1199];

    color_sensor_frontend #(.GATE_CYCLES(100), .SETTLE_CYCLES(10)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sensor_out(sensor_out),
        .s2(s2), .s3(s3), .red_norm(red_norm), .green_norm(green_norm),
        .blue_norm(blue_norm), .valid(valid), .busy(busy)
    );

    color_sensor_frontend #(.GATE_CYCLES(600), .SETTLE_CYCLES(10), .COUNT_BITS(8)) u_sat (
        .clk(clk), .rst(rst), .start(start_b), .sensor_out(sensor_b),
        .s2(s2_b), .s3(s3_b), .red_norm(red_b), .green_norm(green_b),
        .blue_norm(blue_b), .valid(valid_b), .busy(busy_b)
    );

    function automatic int per_a(input logic [1:0] f);
        case (f)
            2'b10:   return 4;
            2'b00:   return 5;
            2'b11:   return 10;
            default: return 4;
        endcase
    endfunction

    function automatic int per_b(input logic [1:0] f);
        case (f)
            2'b10:   return 2;
            2'b00:   return 4;
            2'b11:   return 2;
            default: return 10;
        endcase
    endfunction

    // Sensor models: period follows the filter currently selected by each DUT.
    initial begin
        int ph;
        ph = 0;
        sensor_out = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            if (ph >= per_a({s2, s3})) ph = 0;
            sensor_out = (mode_a != 0) && (ph < per_a({s2, s3}) / 2);
        end
    end

    initial begin
        int ph;
        ph = 0;
        sensor_b = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            if (ph >= per_b({s2_b, s3_b})) ph = 0;
            sensor_b = (ph < per_b({s2_b, s3_b}) / 2);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_main(input int win, input int hold, input int p0, input int p1, input int p2,
                            output int v1, output int v2, output int np, output int red_pre,
                            output int busy_521, output int busy_522, output int busy_end);
        @(negedge clk);
        start = 1'b1;
        v1 = -1; v2 = -1; np = 0; red_pre = -1; busy_521 = -1; busy_522 = -1; busy_end = -1;
        for (int k = 0; k < win; k++) begin
            @(posedge clk);
            #1;
            hist[k] = {s2, s3};
            if (k == 521) begin red_pre = int'(red_norm); busy_521 = int'(busy); end
            if (k == 522) busy_522 = int'(busy);
            if (valid) begin
                np++;
                if (v1 < 0) v1 = k;
                else if (v2 < 0) v2 = k;
            end
            busy_end = int'(busy);
            start = (hold != 0) || (k + 1 == p0) || (k + 1 == p1) || (k + 1 == p2);
        end
        start = 1'b0;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int mode; int hold; int p0; int p1; int p2; int win;
        int v1; int v2; int np; int r; int g; int b; int busy_end;
    } row_t;

    typedef struct { int k; int f; } fpt_t;

    initial begin
        row_t rows [4];
        fpt_t fpts [10];
        int v1, v2, np, red_pre, b521, b522, bend, prev_red, nv, lat;

        rows[0] = '{1, 0, -1, -1, -1,  540, 522,   -1, 1, 819, 409, 1023, 0};
        rows[1] = '{1, 0,  5,  50, 460, 540, 522,   -1, 1, 819, 409, 1023, 0};
        rows[2] = '{0, 0, -1, -1, -1,  540, 522,   -1, 1,   0,   0,    0, 0};
        rows[3] = '{1, 1, -1, -1, -1, 1100, 522, 1045, 2, 819, 409, 1023, 1};
        fpts = '{'{0, 2}, '{109, 2}, '{110, 0}, '{219, 0}, '{220, 3},
                 '{329, 3}, '{330, 1}, '{439, 1}, '{440, 2}, '{530, 2}};

        rst = 1'b1; start = 1'b0; start_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_s2s3", int'({s2, s3}), 0);
        check("rst_red", int'(red_norm), 0);
        check("rst_green", int'(green_norm), 0);
        check("rst_blue", int'(blue_norm), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_s2s3", int'({s2, s3}), 2);

        prev_red = 0;
        for (int i = 0; i < 4; i++) begin
            mode_a = rows[i].mode;
            run_main(rows[i].win, rows[i].hold, rows[i].p0, rows[i].p1, rows[i].p2,
                     v1, v2, np, red_pre, b521, b522, bend);
            check($sformatf("row%0d_valid_cycle", i), v1, rows[i].v1);
            check($sformatf("row%0d_valid2_cycle", i), v2, rows[i].v2);
            check($sformatf("row%0d_valid_count", i), np, rows[i].np);
            check($sformatf("row%0d_red", i), int'(red_norm), rows[i].r);
            check($sformatf("row%0d_green", i), int'(green_norm), rows[i].g);
            check($sformatf("row%0d_blue", i), int'(blue_norm), rows[i].b);
            check($sformatf("row%0d_red_held", i), red_pre, prev_red);
            check($sformatf("row%0d_busy_done", i), b521, 1);
            check($sformatf("row%0d_busy_after", i), b522, 0);
            check($sformatf("row%0d_busy_end", i), bend, rows[i].busy_end);
            if (i == 0)
                foreach (fpts[j])
                    check($sformatf("filter_at_%0d", fpts[j].k), int'(hist[fpts[j].k]), fpts[j].f);
            prev_red = rows[i].r;
        end
        reset_pulse();

        // Reset in the middle of the green gate window.
        mode_a = 1;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k <= 250; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("mid_green_s2s3", int'({s2, s3}), 3);
        check("mid_green_busy", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_s2s3", int'({s2, s3}), 0);
        check("midrst_red", int'(red_norm), 0);
        check("midrst_blue", int'(blue_norm), 0);
        @(posedge clk);
        #1;
        check("midrst_idle_s2s3", int'({s2, s3}), 2);
        nv = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("midrst_no_valid", nv, 0);
        run_main(540, 0, -1, -1, -1, v1, v2, np, red_pre, b521, b522, bend);
        check("rerun_valid_cycle", v1, 522);
        check("rerun_red", int'(red_norm), 819);
        check("rerun_green", int'(green_norm), 409);
        check("rerun_blue", int'(blue_norm), 1023);

        // 8-bit counter instance: clear gate sees 300 edges and must pin at 255.
        @(negedge clk);
        start_b = 1'b1;
        lat = -1;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            start_b = 1'b0;
            if (valid_b) begin
                lat = k;
                break;
            end
        end
        check("sat_valid_cycle", lat, 2522);
        check("sat_red", int'(red_b), 602);
        check("sat_green", int'(green_b), 1023);
        check("sat_blue", int'(blue_b), 240);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
